sine_sched: RTL
===============

SINE_SCHED -- requirements
Module: sine_sched

Interface
REQ-001 Parameter DWIDTH, default 14, shall set the phase sample width per lane.
REQ-002 Parameter UNR, default 4, shall set the unroll factor, i.e. lanes per beat.
REQ-003 Parameter LWIDTH, default 16, shall set the burst-length counter width.
REQ-004 clk  input  1  shall be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  shall be the synchronous, active-high reset.
REQ-006 start  input  1  shall be a one-cycle request to begin a burst.
REQ-007 abort  input  1  shall terminate an active burst.
REQ-008 phase_init  input  DWIDTH  shall be the starting phase of lane 0.
REQ-009 phase_inc  input  DWIDTH  shall be the phase step between adjacent lanes.
REQ-010 burst_len  input  LWIDTH  shall be the number of beats to emit.
REQ-011 out_ready  input  1  shall be the downstream acceptance flag.
REQ-012 out_valid  output  1  shall flag that out_data holds a valid beat.
REQ-013 out_data  output  UNR x (DWIDTH+1)  shall carry the sine results per lane.
REQ-014 out_last  output  1  shall mark the final beat of a burst.
REQ-015 busy  output  1  shall be high whenever the state is not IDLE.
REQ-016 done  output  1  shall pulse for one cycle at normal burst completion.

Function
REQ-017 The FSM shall have states IDLE, RUN and DRAIN.
REQ-018 In IDLE, start=1 with burst_len!=0 and abort=0 shall latch phase_inc and burst_len, load phase<=phase_init, and enter RUN.
REQ-019 In IDLE, start=1 with burst_len=0 shall pulse done on the next cycle, stay in IDLE, and never assert out_valid.
REQ-020 start outside IDLE shall be ignored; config inputs shall not be re-sampled mid-burst.
REQ-021 Load enable shall be (!out_valid || out_ready).
REQ-022 In RUN with load enable, out_data[k] shall load sine(phase + k*inc) for k=0..UNR-1, and out_valid shall be set to 1.
REQ-023 On that same load, phase shall advance by UNR*inc, remaining shall decrement, and out_last shall be set to (remaining==1).
REQ-024 All phase arithmetic shall be modulo 2^DWIDTH, with lane sums truncated to DWIDTH bits.
REQ-025 The first out_valid shall appear 2 cycles after the start edge; with out_ready held at 1, throughput shall be 1 beat/cycle with no bubbles.
REQ-026 While out_valid=1 and out_ready=0, out_data and out_last shall hold stable.
REQ-027 Loading the last beat shall move the FSM to DRAIN.
REQ-028 In DRAIN, the handshake (out_valid && out_ready) shall clear out_valid and out_last, pulse done on the next cycle, and return the FSM to IDLE.
REQ-029 abort=1 in RUN or DRAIN shall, at the next edge, return the FSM to IDLE and clear out_valid and out_last, with no done pulse.
REQ-030 abort=1 and start=1 together in IDLE shall leave the FSM in IDLE (abort wins).
REQ-031 The sine datapath shall be combinational; only the output register adds latency.

Reset
REQ-032 rst=1 shall force state IDLE, with out_valid=0, out_last=0, busy=0, done=0, out_data all zero, and phase, inc and remaining at 0.
REQ-033 rst shall override start and abort, taking effect at the next edge even mid-burst.

Structure
REQ-034 Package sine_pkg shall hold the DWIDTH, UNR and LWIDTH defaults and the state enum typedef (IDLE, RUN, DRAIN).
REQ-035 The block shall instantiate the existing sine module once, with DWIDTH and UNR passed through, fed by an UNR-element lane-phase array.

Verification
REQ-036 The bench shall cover: phase_init=0, inc=100, burst_len=3, out_ready=1 -> beats for phases {0,100,200,300}, {400..700}, {800..1100} on consecutive cycles, out_last on beat 3 only, and done 1 cycle after the final handshake.
REQ-037 The bench shall cover: same burst with out_ready=0 for 5 cycles after beat 1 -> beat 1 held stable for 5 cycles, no beat lost or duplicated, and 3 beats total.
REQ-038 The bench shall cover: phase_init=16300, inc=50, burst_len=1 -> lane phases 16300, 16350, 16, 66.
REQ-039 The bench shall cover: burst_len=0 with start -> done pulse next cycle, out_valid never high, and busy stays 0.
REQ-040 The bench shall cover: abort in cycle 2 of a burst_len=10 burst -> IDLE next edge, out_valid=0, and no done pulse.
REQ-041 The bench shall cover: rst mid-burst -> all outputs at reset values next cycle, after which a fresh start behaves normally.

Source files
------------

// File: rtl/sine_pkg.sv
// Shared defaults and FSM state type for the sine burst scheduler.
package sine_pkg;

  localparam int SINE_DWIDTH = 14;
  localparam int SINE_UNR    = 4;
  localparam int SINE_LWIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/sine.sv
// Combinational multi-lane sine: parabolic approximation of one full period
// over 2^DWIDTH phase steps, amplitude 2^(DWIDTH-1), two's complement lanes.
module sine
  import sine_pkg::*;
#(
  parameter int DWIDTH = SINE_DWIDTH,
  parameter int UNR    = SINE_UNR
) (
  input  logic [UNR-1:0][DWIDTH-1:0] phase_i,
  output logic [UNR-1:0][DWIDTH:0]   sine_o
);

  localparam int HALF  = 1 << (DWIDTH - 1);
  localparam int SHIFT = DWIDTH - 3;

  // Each half period is x*(HALF-x) scaled so the peak lands on HALF;
  // the phase MSB selects the negative half.
  function automatic logic signed [DWIDTH:0] para_sin(input logic [DWIDTH-1:0] p);
    logic [DWIDTH-2:0]   x;
    logic [DWIDTH-1:0]   xc;
    logic [2*DWIDTH-2:0] prod;
    logic [DWIDTH:0]     mag;
    x    = p[DWIDTH-2:0];
    xc   = DWIDTH'(HALF) - {1'b0, x};
    prod = (2*DWIDTH-1)'(x) * (2*DWIDTH-1)'(xc);
    mag  = (DWIDTH+1)'(prod >> SHIFT);
    return p[DWIDTH-1] ? -$signed(mag) : $signed(mag);
  endfunction

  always_comb begin
    for (int k = 0; k < UNR; k++) begin
      sine_o[k] = para_sin(phase_i[k]);
    end
  end

endmodule

// File: rtl/sine_sched.sv
// Burst scheduler: emits burst_len beats of UNR sine lanes per beat over a
// valid/ready output register, stepping the lane phase by phase_inc.
module sine_sched
  import sine_pkg::*;
#(
  parameter int DWIDTH = SINE_DWIDTH,
  parameter int UNR    = SINE_UNR,
  parameter int LWIDTH = SINE_LWIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [DWIDTH-1:0]          phase_init,
  input  logic [DWIDTH-1:0]          phase_inc,
  input  logic [LWIDTH-1:0]          burst_len,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [UNR-1:0][DWIDTH:0]   out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  state_e                     state_q;
  logic [DWIDTH-1:0]          phase_q;
  logic [DWIDTH-1:0]          phase_d;
  logic [DWIDTH-1:0]          inc_q;
  logic [LWIDTH-1:0]          remain_q;
  logic                       valid_q;
  logic                       last_q;
  logic                       done_q;
  logic [UNR-1:0][DWIDTH:0]   data_q;
  logic [UNR-1:0][DWIDTH-1:0] lane_phase;
  logic [UNR-1:0][DWIDTH:0]   lane_sin;
  logic                       load_en;

  assign load_en = !valid_q || out_ready;
  assign phase_d = phase_q + DWIDTH'(UNR) * inc_q;

  // Lane sums wrap modulo 2^DWIDTH by truncation.
  always_comb begin
    for (int k = 0; k < UNR; k++) begin
      lane_phase[k] = phase_q + DWIDTH'(k) * inc_q;
    end
  end

  sine #(
    .DWIDTH (DWIDTH),
    .UNR    (UNR)
  ) u_sine (
    .phase_i (lane_phase),
    .sine_o  (lane_sin)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      inc_q    <= '0;
      remain_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            if (burst_len == '0) begin
              done_q <= 1'b1;
            end else begin
              phase_q  <= phase_init;
              inc_q    <= phase_inc;
              remain_q <= burst_len;
              state_q  <= RUN;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end else if (load_en) begin
            data_q   <= lane_sin;
            valid_q  <= 1'b1;
            last_q   <= (remain_q == LWIDTH'(1));
            phase_q  <= phase_d;
            remain_q <= remain_q - LWIDTH'(1);
            if (remain_q == LWIDTH'(1)) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end else if (valid_q && out_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_data  = data_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

endmodule
